child_inst_sequencer: RTL

//  Sits directly above a fan-out node of the generated rootModule hierarchy. It brings up that

---
 rtl/child_seq_pkg.sv | 17 +
 rtl/child_watchdog.sv | 44 ++++
 rtl/child_inst_sequencer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/child_seq_pkg.sv
// Shared types and defaults for the child instance sequencer.
//   seq_state_t : sequencer FSM states
//   DEF_*       : default parameter values
//   idx_w()     : index width for a given child count (at least 1 bit)
package child_seq_pkg;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, REPORT} seq_state_t;

  localparam int unsigned DEF_NUM_CHILD = 5;
  localparam int unsigned DEF_TIMEOUT   = 200;
  localparam int unsigned DEF_TO_W      = 8;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/child_watchdog.sv
// Per-child watchdog counter.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : zero the counter (wins over en)
//   en       : count one cycle, saturating at TIMEOUT
//   expired  : counter has reached TIMEOUT-1
module child_watchdog
  import child_seq_pkg::*;
#(
  parameter int unsigned TO_W    = DEF_TO_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TO_W-1:0] SAT  = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q < SAT)) begin
      cnt_d = cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // >= rather than == keeps the flag valid once the counter saturates
  assign expired = (cnt_q >= LAST);

endmodule

// File: rtl/child_inst_sequencer.sv
// Brings up NUM_CHILD child instances strictly in index order, one at a time,
// with a per-child watchdog; returns a single status beat upstream.
//   clk, rst           : clock, asynchronous active-high reset
//   start_valid/ready  : request to run the whole sequence (ready only when idle)
//   child_start        : one-cycle one-hot start pulse to the active child
//   child_done         : completion indication from each child
//   rsp_valid/ready    : status beat handshake
//   rsp_ok             : 1 = every child completed, 0 = aborted on timeout
//   rsp_idx            : failing child, or NUM_CHILD-1 on success
//   rsp_spurious       : a non-active child signalled done during the run
module child_inst_sequencer
  import child_seq_pkg::*;
#(
  parameter int unsigned NUM_CHILD = DEF_NUM_CHILD,
  parameter int unsigned TIMEOUT   = DEF_TIMEOUT,
  parameter int unsigned TO_W      = DEF_TO_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_valid,
  output logic                          start_ready,
  output logic [NUM_CHILD-1:0]          child_start,
  input  logic [NUM_CHILD-1:0]          child_done,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic                          rsp_ok,
  output logic [idx_w(NUM_CHILD)-1:0]   rsp_idx,
  output logic                          rsp_spurious
);

  localparam int unsigned      IDX_W    = idx_w(NUM_CHILD);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHILD - 1);

  seq_state_t           state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W-1:0]     rsp_idx_q, rsp_idx_d;
  logic                 rsp_ok_q, rsp_ok_d;
  logic                 spur_q, spur_d;

  logic [NUM_CHILD-1:0] active_mask;
  logic                 done_hit;
  logic                 done_other;
  logic                 wd_clr;
  logic                 wd_en;
  logic                 wd_expired;

  // Mask-based selection avoids indexing past NUM_CHILD when it is not a power of two
  assign active_mask = NUM_CHILD'(1) << idx_q;
  assign done_hit    = |(child_done & active_mask);
  assign done_other  = |(child_done & ~active_mask);

  // Counter is zero during LAUNCH and counts through LAUNCH and WAIT, so the
  // abort decision lands TIMEOUT-1 cycles after the start pulse.
  assign wd_clr = (state_d == LAUNCH);
  assign wd_en  = (state_q == LAUNCH) || (state_q == WAIT);

  child_watchdog #(
    .TO_W    (TO_W),
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (wd_clr),
    .en      (wd_en),
    .expired (wd_expired)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rsp_idx_d = rsp_idx_q;
    rsp_ok_d  = rsp_ok_q;
    spur_d    = spur_q;
    case (state_q)
      IDLE: begin
        if (start_valid) begin
          idx_d   = '0;
          spur_d  = 1'b0;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        if (done_other) begin
          spur_d = 1'b1;
        end
        state_d = WAIT;
      end
      WAIT: begin
        if (done_other) begin
          spur_d = 1'b1;
        end
        // Done takes priority over a coincident timeout
        if (done_hit) begin
          if (idx_q == LAST_IDX) begin
            rsp_ok_d  = 1'b1;
            rsp_idx_d = idx_q;
            state_d   = REPORT;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = LAUNCH;
          end
        end else if (wd_expired) begin
          rsp_ok_d  = 1'b0;
          rsp_idx_d = idx_q;
          state_d   = REPORT;
        end
      end
      REPORT: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      rsp_idx_q <= '0;
      rsp_ok_q  <= 1'b0;
      spur_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rsp_idx_q <= rsp_idx_d;
      rsp_ok_q  <= rsp_ok_d;
      spur_q    <= spur_d;
    end
  end

  // Decoded from the state register so reset removes them immediately
  assign start_ready  = (state_q == IDLE);
  assign rsp_valid    = (state_q == REPORT);
  assign child_start  = (state_q == LAUNCH) ? active_mask : '0;
  assign rsp_ok       = rsp_ok_q;
  assign rsp_idx      = rsp_idx_q;
  assign rsp_spurious = spur_q;

endmodule
